// File: rtl/stack_unit_if.sv
// Request/response bundle between the decode stage and the hardware stack.
interface stack_unit_if #(
   parameter int DATA_W = 32,
   parameter int PTR_W  = 4
);
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_data;
   logic              err_clr;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic              full;
   logic              empty;
   logic [PTR_W:0]    count;
   logic              overflow;
   logic              underflow;
   logic              fault;

   modport master (
      output push, pop, push_data, err_clr,
      input  pop_data, pop_valid, full, empty, count, overflow, underflow, fault
   );

   modport slave (
      input  push, pop, push_data, err_clr,
      output pop_data, pop_valid, full, empty, count, overflow, underflow, fault
   );
endinterface

// File: rtl/stack_unit.sv
// Hardware LIFO for PUSH/POP instructions with sticky error flags and a
// FAULT state that freezes the stack until err_clr.
//
// state | meaning
// RUN   | push/pop requests serviced
// FAULT | a request was refused; stack frozen until err_clr
module stack_unit #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
) (
   input logic          clk,
   input logic          rst,
   stack_unit_if.slave  bus
);
   typedef enum logic {RUN, FAULT} state_t;

   state_t            state;
   logic [PTR_W:0]    count;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic              overflow;
   logic              underflow;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              full_i;
   logic              empty_i;
   logic [PTR_W-1:0]  top_idx;
   logic [PTR_W-1:0]  wr_idx;
   logic              wr_en;

   assign full_i  = (count == (PTR_W+1)'(DEPTH));
   assign empty_i = (count == '0);
   // Wraps to DEPTH-1 when full, which is exactly the top entry.
   assign top_idx = count[PTR_W-1:0] - PTR_W'(1);

   // Simultaneous push+pop replaces the top; a plain push appends.
   always_comb begin
      wr_idx = count[PTR_W-1:0];
      wr_en  = 1'b0;
      if (rst && state == RUN && bus.push) begin
         if (bus.pop) begin
            wr_idx = top_idx;
            wr_en  = !empty_i;
         end else begin
            wr_en  = !full_i;
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_idx] <= bus.push_data;
   end

   // Control FSM, occupancy counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         count     <= '0;
         pop_data  <= '0;
         pop_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pop_valid <= 1'b0;
         case (state)
            RUN: begin
               if (bus.push && bus.pop) begin
                  pop_valid <= 1'b1;
                  if (empty_i)
                     pop_data <= bus.push_data;
                  else
                     pop_data <= mem[top_idx];
               end else if (bus.push) begin
                  if (full_i) begin
                     overflow <= 1'b1;
                     state    <= FAULT;
                  end else begin
                     count <= count + 1'b1;
                  end
               end else if (bus.pop) begin
                  if (empty_i) begin
                     underflow <= 1'b1;
                     state     <= FAULT;
                  end else begin
                     pop_data  <= mem[top_idx];
                     count     <= count - 1'b1;
                     pop_valid <= 1'b1;
                  end
               end
            end
            FAULT: begin
               if (bus.err_clr) begin
                  state     <= RUN;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign bus.pop_data  = pop_data;
   assign bus.pop_valid = pop_valid;
   assign bus.full      = full_i;
   assign bus.empty     = empty_i;
   assign bus.count     = count;
   assign bus.overflow  = overflow;
   assign bus.underflow = underflow;
   assign bus.fault     = (state == FAULT);
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with hand-computed expectations.
module tb_stack_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   stack_unit_if #(.DATA_W(32), .PTR_W(4)) bus ();

   stack_unit #(.DATA_W(32), .DEPTH(16), .PTR_W(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock with the given request; inputs return to idle after the edge.
   task automatic cyc(input logic p, input logic po, input logic [31:0] d, input logic ec);
      bus.push      = p;
      bus.pop       = po;
      bus.push_data = d;
      bus.err_clr   = ec;
      @(posedge clk);
      #1;
      bus.push    = 1'b0;
      bus.pop     = 1'b0;
      bus.err_clr = 1'b0;
   endtask

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.err_clr = 1'b0;
      rst = 1'b0;
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_pop_valid", 64'(bus.pop_valid), 64'd0);
      chk("rst_pop_data", 64'(bus.pop_data), 64'd0);
      chk("rst_empty", 64'(bus.empty), 64'd1);
      chk("rst_fault", 64'(bus.fault), 64'd0);

      // Basic LIFO order.
      cyc(1'b1, 1'b0, 32'hA, 1'b0);
      cyc(1'b1, 1'b0, 32'hB, 1'b0);
      cyc(1'b1, 1'b0, 32'hC, 1'b0);
      chk("lifo_count3", 64'(bus.count), 64'd3);
      chk("lifo_empty0", 64'(bus.empty), 64'd0);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("lifo_pv1", 64'(bus.pop_valid), 64'd1);
      chk("lifo_pd1", 64'(bus.pop_data), 64'hC);
      chk("lifo_cnt2", 64'(bus.count), 64'd2);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("lifo_pv2", 64'(bus.pop_valid), 64'd1);
      chk("lifo_pd2", 64'(bus.pop_data), 64'hB);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("lifo_pv3", 64'(bus.pop_valid), 64'd1);
      chk("lifo_pd3", 64'(bus.pop_data), 64'hA);
      chk("lifo_cnt0", 64'(bus.count), 64'd0);
      chk("lifo_empty1", 64'(bus.empty), 64'd1);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("pv_pulse", 64'(bus.pop_valid), 64'd0);

      // Fill, overflow, frozen pop, clear.
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
      chk("fill_count", 64'(bus.count), 64'd16);
      chk("fill_full", 64'(bus.full), 64'd1);
      cyc(1'b1, 1'b0, 32'h55, 1'b0);
      chk("ovf_flag", 64'(bus.overflow), 64'd1);
      chk("ovf_fault", 64'(bus.fault), 64'd1);
      chk("ovf_count", 64'(bus.count), 64'd16);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("fault_pop_pv", 64'(bus.pop_valid), 64'd0);
      chk("fault_pop_cnt", 64'(bus.count), 64'd16);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("clr_fault", 64'(bus.fault), 64'd0);
      chk("clr_ovf", 64'(bus.overflow), 64'd0);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("post_clr_pd", 64'(bus.pop_data), 64'h10F);
      chk("post_clr_cnt", 64'(bus.count), 64'd15);
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("drain_pd", 64'(bus.pop_data), 64'h100);
      chk("drain_cnt", 64'(bus.count), 64'd0);

      // Underflow from empty.
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("udf_flag", 64'(bus.underflow), 64'd1);
      chk("udf_pv", 64'(bus.pop_valid), 64'd0);
      chk("udf_pd_held", 64'(bus.pop_data), 64'h100);
      chk("udf_fault", 64'(bus.fault), 64'd1);
      cyc(1'b1, 1'b0, 32'h1, 1'b0);
      chk("fault_push_cnt", 64'(bus.count), 64'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("clr_udf", 64'(bus.underflow), 64'd0);

      // Simultaneous push+pop on a non-empty stack.
      cyc(1'b1, 1'b0, 32'h10, 1'b0);
      cyc(1'b1, 1'b0, 32'h20, 1'b0);
      cyc(1'b1, 1'b1, 32'h30, 1'b0);
      chk("pp_pv", 64'(bus.pop_valid), 64'd1);
      chk("pp_pd", 64'(bus.pop_data), 64'h20);
      chk("pp_cnt", 64'(bus.count), 64'd2);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("pp_next_pd", 64'(bus.pop_data), 64'h30);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("pp_last_pd", 64'(bus.pop_data), 64'h10);
      chk("pp_last_cnt", 64'(bus.count), 64'd0);

      // Bypass on empty.
      cyc(1'b1, 1'b1, 32'h77, 1'b0);
      chk("byp_pv", 64'(bus.pop_valid), 64'd1);
      chk("byp_pd", 64'(bus.pop_data), 64'h77);
      chk("byp_cnt", 64'(bus.count), 64'd0);
      chk("byp_err", 64'({bus.overflow, bus.underflow, bus.fault}), 64'd0);

      // Reset during a pop wins.
      cyc(1'b1, 1'b0, 32'h1, 1'b0);
      cyc(1'b1, 1'b0, 32'h2, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      rst = 1'b1;
      chk("rst2_count", 64'(bus.count), 64'd0);
      chk("rst2_pv", 64'(bus.pop_valid), 64'd0);
      chk("rst2_pd", 64'(bus.pop_data), 64'd0);
      chk("rst2_fault", 64'(bus.fault), 64'd0);

      // Push immediately visible to the next pop.
      cyc(1'b1, 1'b0, 32'h9, 1'b0);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk("fwd_pd", 64'(bus.pop_data), 64'h9);
      chk("fwd_pv", 64'(bus.pop_valid), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
